bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan_if.sv | 40 ++++
 rtl/bcd_display_scan.sv | 178 +++++++++++++++++
 tb/tb_bcd_display_scan.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scan_if.sv
// Digit/control bundle for the bcd_display_scan four-digit LED scanner.
// master: drives digits, load, blank_lz, blink_en; slave: drives an, seg, frame_done.
interface bcd_display_scan_if;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] wickets;
  logic       load;
  logic       blank_lz;
  logic       blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  modport master (
    output hundreds,
    output tens,
    output ones,
    output wickets,
    output load,
    output blank_lz,
    output blink_en,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  hundreds,
    input  tens,
    input  ones,
    input  wickets,
    input  load,
    input  blank_lz,
    input  blink_en,
    output an,
    output seg,
    output frame_done
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit 7-segment scanner with frame-synchronous digit update.
// Ports: clk, reset (async, active-high), bus (slave: digits/load/blank_lz/blink_en in; an/seg/frame_done out).
module bcd_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64
) (
  input  logic              clk,
  input  logic              reset,
  bcd_display_scan_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [3:0] w;
  } digits_t;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  digits_t       r_shadow;
  digits_t       r_disp;
  logic          r_pend;
  logic          r_phase;
  logic [BW-1:0] r_fcnt;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_tick;
  logic          w_bound;
  digits_t       w_in;
  logic [3:0]    w_digit;
  logic [3:0]    w_anode;
  logic [6:0]    w_seg;
  logic          w_zero_h;
  logic          w_zero_t;
  logic          w_lz;
  logic          w_blank;

  // Active-low {g,f,e,d,c,b,a}; A/B blank, C-F are score-board glyphs.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b1111111;
      4'hB: s = 7'b1111111;
      4'hC: s = 7'b1011111;
      4'hD: s = 7'b1001111;
      4'hE: s = 7'b1111101;
      4'hF: s = 7'b0000111;
    endcase
    return s;
  endfunction

  assign w_tick  = (r_presc == P_LAST);
  assign w_bound = w_tick && (r_idx == 2'd0);

  assign w_in.h = bus.hundreds;
  assign w_in.t = bus.tens;
  assign w_in.o = bus.ones;
  assign w_in.w = bus.wickets;

  // Scan timing: index counts down, 0 wraps back to 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd3;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx - 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Shadow/display pair: new digits only become visible at a
  // frame boundary so a frame never shows mixed old/new digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_disp   <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow <= w_in;
      end
      if (w_bound) begin
        if (bus.load) begin
          r_disp <= w_in;
          r_pend <= 1'b0;
        end else if (r_pend) begin
          r_disp <= r_shadow;
          r_pend <= 1'b0;
        end
      end else if (bus.load) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Blink phase flips every BLINK_DIV completed frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_fcnt  <= '0;
    end else if (!bus.blink_en) begin
      r_phase <= 1'b0;
      r_fcnt  <= '0;
    end else if (w_bound) begin
      if (r_fcnt == B_LAST) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + BW'(1);
      end
    end
  end

  always_comb begin
    w_digit = r_disp.w;
    unique case (r_idx)
      2'd3: w_digit = r_disp.h;
      2'd2: w_digit = r_disp.t;
      2'd1: w_digit = r_disp.o;
      2'd0: w_digit = r_disp.w;
    endcase
  end

  assign w_anode  = ~(4'b0001 << r_idx);
  assign w_seg    = seg_decode(w_digit);
  assign w_zero_h = (r_disp.h == 4'h0);
  assign w_zero_t = (r_disp.t == 4'h0);

  // Tens is only a leading zero when hundreds is also zero.
  always_comb begin
    w_lz = 1'b0;
    unique case (1'b1)
      (r_idx == 2'd3): w_lz = w_zero_h;
      (r_idx == 2'd2): w_lz = w_zero_h && w_zero_t;
      default:         w_lz = 1'b0;
    endcase
  end

  assign w_blank = r_phase || (bus.blank_lz && w_lz);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= w_anode;
      r_seg <= w_seg;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_done = w_bound;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: frame-level reference model,
// directed scenarios followed by randomized loads/controls/resets.
module tb_bcd_display_scan;

  localparam int R  = 4;
  localparam int B  = 2;
  localparam int FR = 4 * R;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    int         e;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bcd_display_scan_if bus ();

  bcd_display_scan #(
    .REFRESH_DIV(R),
    .BLINK_DIV  (B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sbq[$];

  // reference model state; slot 3=hundreds ... 0=wickets
  int         m_e;
  logic [3:0] m_disp[4];
  logic [3:0] m_new[4];
  bit         m_pend;
  bit         m_phase;
  int         m_fcnt;

  string lit_tbl[16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "", "", "f", "ef", "b", "defg"
  };

  // segment pattern built from the list of lit segment letters
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] m;
    string s;
    m = 7'h7F;
    s = lit_tbl[d];
    for (int i = 0; i < s.len(); i++) begin
      m[s[i] - 8'd97] = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // model: one expectation per clock edge
  always @(posedge clk) begin
    if (reset) begin
      m_e = 0;
      m_pend = 0;
      m_phase = 0;
      m_fcnt = 0;
      for (int k = 0; k < 4; k++) begin
        m_disp[k] = 4'h0;
        m_new[k] = 4'h0;
      end
      sbq.delete();
    end else begin
      exp_t x;
      int slot;
      bit lz;
      bit bnd;
      m_e++;
      slot = 3 - (((m_e - 1) / R) % 4);
      lz = 0;
      if (slot == 3) lz = (m_disp[3] == 0);
      if (slot == 2) lz = (m_disp[3] == 0) && (m_disp[2] == 0);
      for (int k = 0; k < 4; k++) x.an[k] = (k != slot);
      x.seg = seg_of(m_disp[slot]);
      if (m_phase || (bus.blank_lz && lz)) begin
        x.an = 4'hF;
        x.seg = 7'h7F;
      end
      x.fd = ((m_e + 1) % FR) == 0;
      x.e = m_e;
      sbq.push_back(x);
      bnd = (m_e % FR) == 0;
      if (bnd && bus.load) begin
        m_disp[3] = bus.hundreds;
        m_disp[2] = bus.tens;
        m_disp[1] = bus.ones;
        m_disp[0] = bus.wickets;
        m_pend = 0;
      end else if (bnd && m_pend) begin
        m_disp = m_new;
        m_pend = 0;
      end else if (bus.load) begin
        m_new[3] = bus.hundreds;
        m_new[2] = bus.tens;
        m_new[1] = bus.ones;
        m_new[0] = bus.wickets;
        m_pend = 1;
      end
      if (!bus.blink_en) begin
        m_fcnt = 0;
        m_phase = 0;
      end else if (bnd) begin
        m_fcnt++;
        if (m_fcnt == B) begin
          m_fcnt = 0;
          m_phase = !m_phase;
        end
      end
    end
  end

  // monitor
  exp_t mx;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_an", 32'(bus.an), 32'h0F);
      chk("rst_seg", 32'(bus.seg), 32'h7F);
      chk("rst_fd", 32'(bus.frame_done), 32'h0);
    end else if (sbq.size() > 0) begin
      mx = sbq.pop_front();
      chk($sformatf("an e=%0d", mx.e), 32'(bus.an), 32'(mx.an));
      chk($sformatf("seg e=%0d", mx.e), 32'(bus.seg), 32'(mx.seg));
      chk($sformatf("fd e=%0d", mx.e), 32'(bus.frame_done), 32'(mx.fd));
    end else begin
      chk("sb_empty", 32'(sbq.size()), 32'd1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // wait for the negedge after edge count m_e hits r (mod FR)
  task automatic sync_to(input int r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_e % FR) != r && n < 200);
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sync_timeout: got m_e=%0d expected phase %0d", m_e, r);
    end
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input logic [3:0] w);
    bus.hundreds = h;
    bus.tens = t;
    bus.ones = o;
    bus.wickets = w;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_reset(input bit direct);
    @(posedge clk);
    #1 reset = 1'b1;
    if (direct) begin
      #1;
      chk("rst_now_an", 32'(bus.an), 32'h0F);
      chk("rst_now_seg", 32'(bus.seg), 32'h7F);
    end
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    bus.hundreds = 4'h0;
    bus.tens = 4'h0;
    bus.ones = 4'h0;
    bus.wickets = 4'h0;
    bus.load = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    cycles(3);
    #1 reset = 1'b0;
    cycles(FR);

    sync_to(3);
    do_load(4'h1, 4'h2, 4'h3, 4'h4);
    cycles(3 * FR);

    sync_to(9);
    do_load(4'h9, 4'h8, 4'h7, 4'h6);
    cycles(2 * FR);

    sync_to(FR - 1);
    do_load(4'h5, 4'h0, 4'h4, 4'h2);
    cycles(FR);

    bus.blank_lz = 1'b1;
    sync_to(FR - 1);
    do_load(4'h0, 4'h0, 4'h5, 4'h2);
    cycles(2 * FR);
    do_load(4'h0, 4'h4, 4'h0, 4'h1);
    cycles(2 * FR);
    do_load(4'hA, 4'h0, 4'h3, 4'h3);
    cycles(2 * FR);
    bus.blank_lz = 1'b0;

    do_load(4'hF, 4'h0, 4'h1, 4'h0);
    cycles(2 * FR);
    do_load(4'hC, 4'hD, 4'h0, 4'hE);
    cycles(2 * FR);

    sync_to(0);
    bus.blink_en = 1'b1;
    cycles(7 * FR);
    bus.blink_en = 1'b0;
    cycles(FR);

    do_load(4'h8, 4'h8, 4'h8, 4'h8);
    cycles(2 * FR);
    sync_to(5);
    do_load(4'h7, 4'h7, 4'h7, 4'h7);
    pulse_reset(1'b1);
    cycles(2 * FR);

    for (int it = 0; it < 300; it++) begin
      int a;
      a = int'($urandom_range(0, 99));
      if (a < 45) begin
        do_load(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end else if (a < 65) begin
        bus.blank_lz = ~bus.blank_lz;
      end else if (a < 80) begin
        bus.blink_en = ~bus.blink_en;
      end else if (a < 83) begin
        pulse_reset(1'b0);
      end else if (a < 90) begin
        bus.hundreds = 4'h0;
        bus.tens = 4'($urandom_range(0, 1));
        do_load(4'h0, bus.tens, 4'($urandom), 4'($urandom));
      end
      cycles(int'($urandom_range(1, 20)));
    end
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
